// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: operand record, fetch entry and buffer state.
// Also holds the CDB match helper used by capture-time resolve and held-entry snoop.
package ooo_pkg;

  localparam int OOO_BITWIDTH = 32;
  localparam int OOO_RF_DEPTH = 32;
  localparam int OOO_RS_DEPTH = 32;
  localparam int OOO_RW       = $clog2(OOO_RF_DEPTH);
  localparam int OOO_TW       = $clog2(OOO_RS_DEPTH);

  typedef struct packed {
    logic                    busy;
    logic [OOO_TW-1:0]       tag;
    logic [OOO_BITWIDTH-1:0] value;
  } operand_t;

  typedef struct packed {
    operand_t op1;
    operand_t op2;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // A waiting operand whose producer broadcasts this cycle becomes ready with the result.
  function automatic operand_t cdb_snoop(input operand_t op, input logic cdb_v,
                                         input logic [OOO_TW-1:0] cdb_t,
                                         input logic [OOO_BITWIDTH-1:0] cdb_val);
    operand_t r;
    r = op;
    if (op.busy && cdb_v && (op.tag == cdb_t)) begin
      r.busy  = 1'b0;
      r.value = cdb_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/operand_resolve.sv
// Combinational resolve of one source operand: x0 forcing, RAT read,
// optional same-cycle rename-write bypass (RAT_WRITE_BYPASS_EN), then CDB merge.
module operand_resolve
  import ooo_pkg::*;
(
  input  logic [OOO_RW-1:0]       rs_i,
  input  logic                    rat_busy_i,
  input  logic [OOO_TW-1:0]       rat_tag_i,
  input  logic [OOO_BITWIDTH-1:0] rat_value_i,
`ifdef RAT_WRITE_BYPASS_EN
  input  logic                    rat_wen_i,
  input  logic [OOO_RW-1:0]       rat_wrd_i,
  input  logic [OOO_TW-1:0]       rat_wtag_i,
`endif
  input  logic                    cdb_valid_i,
  input  logic [OOO_TW-1:0]       cdb_tag_i,
  input  logic [OOO_BITWIDTH-1:0] cdb_value_i,
  output operand_t                op_o
);

  operand_t rd;

  // Build the raw read, then let a same-cycle broadcast resolve it.
  always_comb begin
    rd = '0;
    if (rs_i != '0) begin
      rd.busy  = rat_busy_i;
      rd.tag   = rat_tag_i;
      rd.value = rat_value_i;
`ifdef RAT_WRITE_BYPASS_EN
      // An older instruction renaming this register in the same cycle wins over the stale read.
      if (rat_wen_i && (rat_wrd_i == rs_i)) begin
        rd.busy = 1'b1;
        rd.tag  = rat_wtag_i;
      end
`endif
    end
    op_o = cdb_snoop(rd, cdb_valid_i, cdb_tag_i, cdb_value_i);
  end

endmodule

// File: rtl/rat_operand_fetch.sv
// Dispatch-side RAT read port: resolves rs1/rs2 into {busy, tag, value} and holds
// results in a 2-entry head/skid buffer that keeps snooping the CDB until consumed.
// Optional feature macro: RAT_WRITE_BYPASS_EN (same-cycle rename-write bypass).
module rat_operand_fetch
  import ooo_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int RF_DEPTH = 32,
  parameter int RS_DEPTH = 32,
  localparam int RW = $clog2(RF_DEPTH),
  localparam int TW = $clog2(RS_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [RW-1:0]       req_rs1,
  input  logic [RW-1:0]       req_rs2,
  output logic [RW-1:0]       rat_raddr1,
  output logic [RW-1:0]       rat_raddr2,
  input  logic                rat_busy1,
  input  logic [TW-1:0]       rat_tag1,
  input  logic [BITWIDTH-1:0] rat_value1,
  input  logic                rat_busy2,
  input  logic [TW-1:0]       rat_tag2,
  input  logic [BITWIDTH-1:0] rat_value2,
`ifdef RAT_WRITE_BYPASS_EN
  input  logic                rat_wen,
  input  logic [RW-1:0]       rat_wrd,
  input  logic [TW-1:0]       rat_wtag,
`endif
  input  logic                cdb_valid,
  input  logic [TW-1:0]       cdb_tag,
  input  logic [BITWIDTH-1:0] cdb_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_op1_busy,
  output logic [TW-1:0]       out_op1_tag,
  output logic [BITWIDTH-1:0] out_op1_value,
  output logic                out_op2_busy,
  output logic [TW-1:0]       out_op2_tag,
  output logic [BITWIDTH-1:0] out_op2_value
);

  state_t       state_q, state_d;
  fetch_entry_t head_q, head_d;
  fetch_entry_t skid_q, skid_d;
  fetch_entry_t new_entry;
  fetch_entry_t head_snp, skid_snp;
  logic         push, pop;

  assign rat_raddr1 = req_rs1;
  assign rat_raddr2 = req_rs2;

  operand_resolve u_res1 (
    .rs_i        (req_rs1),
    .rat_busy_i  (rat_busy1),
    .rat_tag_i   (rat_tag1),
    .rat_value_i (rat_value1),
`ifdef RAT_WRITE_BYPASS_EN
    .rat_wen_i   (rat_wen),
    .rat_wrd_i   (rat_wrd),
    .rat_wtag_i  (rat_wtag),
`endif
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .cdb_value_i (cdb_value),
    .op_o        (new_entry.op1)
  );

  operand_resolve u_res2 (
    .rs_i        (req_rs2),
    .rat_busy_i  (rat_busy2),
    .rat_tag_i   (rat_tag2),
    .rat_value_i (rat_value2),
`ifdef RAT_WRITE_BYPASS_EN
    .rat_wen_i   (rat_wen),
    .rat_wrd_i   (rat_wrd),
    .rat_wtag_i  (rat_wtag),
`endif
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .cdb_value_i (cdb_value),
    .op_o        (new_entry.op2)
  );

  assign req_ready = rst & (state_q != FULL) & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign push      = req_valid & req_ready;
  assign pop       = out_valid & out_ready;

  // Held entries pick up any matching broadcast whether or not they move this cycle.
  always_comb begin
    head_snp.op1 = cdb_snoop(head_q.op1, cdb_valid, cdb_tag, cdb_value);
    head_snp.op2 = cdb_snoop(head_q.op2, cdb_valid, cdb_tag, cdb_value);
    skid_snp.op1 = cdb_snoop(skid_q.op1, cdb_valid, cdb_tag, cdb_value);
    skid_snp.op2 = cdb_snoop(skid_q.op2, cdb_valid, cdb_tag, cdb_value);
  end

  // Next-state and buffer movement; flush dominates push/pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_snp;
    skid_d  = skid_snp;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
        ONE: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            skid_d  = new_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          head_d  = skid_snp;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry registers; reset clears everything so out_* read as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign out_op1_busy  = head_q.op1.busy;
  assign out_op1_tag   = head_q.op1.tag;
  assign out_op1_value = head_q.op1.value;
  assign out_op2_busy  = head_q.op2.busy;
  assign out_op2_tag   = head_q.op2.tag;
  assign out_op2_value = head_q.op2.value;

endmodule
